ssid_stim_sequencer: RTL and testbench



---
 rtl/ssid_stim_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ssid_stim_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssid_stim_sequencer.sv
// Replays a loadable SSID table into the HNM write port and checks every returned
// SSID/hit pair against the table, keeping saturating run counters for debug readout.
module ssid_stim_sequencer #(
  parameter int SSIDBITS      = 16,
  parameter int DEPTH         = 32,
  parameter int ADDRBITS      = 5,
  parameter int GAPBITS       = 4,
  parameter int CNTBITS       = 16,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  logic [ADDRBITS-1:0] load_addr,
  input  logic [SSIDBITS-1:0] load_ssid,
  input  logic                load_expHit,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDRBITS:0]   nEntries,
  input  logic [7:0]          nLoops,
  input  logic [GAPBITS-1:0]  gap,
  input  logic                writeReady,
  output logic                write,
  output logic [SSIDBITS-1:0] SSID_write,
  input  logic                newOutput,
  input  logic [SSIDBITS-1:0] SSID_passed,
  input  logic                hitExisted,
  output logic                busy,
  output logic                done,
  output logic [CNTBITS-1:0]  nSent,
  output logic [CNTBITS-1:0]  nReceived,
  output logic [CNTBITS-1:0]  nMismatch,
  output logic                orphan,
  output logic                timeout,
  output logic [2:0]          dbg_state
);

  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Handshake: a write is accepted by HNM in any cycle where ISSUE sees writeReady=1;
  // the registered write strobe follows one cycle later, high for exactly that cycle.
  // HNM responses are valid whenever newOutput=1 and are never back-pressured.

  logic [SSIDBITS-1:0] tbl     [DEPTH];
  logic                exp_tbl [DEPTH];

  state_t              state_q,     state_d;
  logic                write_q,     write_d;
  logic [SSIDBITS-1:0] ssid_q,      ssid_d;
  logic [CNTBITS-1:0]  n_sent_q,    n_sent_d;
  logic [CNTBITS-1:0]  n_recv_q,    n_recv_d;
  logic [CNTBITS-1:0]  n_mis_q,     n_mis_d;
  logic                orphan_q,    orphan_d;
  logic                timeout_q,   timeout_d;
  logic [ADDRBITS-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDRBITS-1:0] rd_ptr_q,    rd_ptr_d;
  logic [7:0]          wr_pass_q,   wr_pass_d;
  logic [7:0]          rd_pass_q,   rd_pass_d;
  logic [ADDRBITS-1:0] last_idx_q,  last_idx_d;
  logic [7:0]          n_loops_q,   n_loops_d;
  logic [GAPBITS-1:0]  gap_q,       gap_d;
  logic [GAPBITS-1:0]  gap_cnt_q,   gap_cnt_d;
  logic [DW-1:0]       drain_cnt_q, drain_cnt_d;

  logic                exp_hit;
  logic                last_write;

  function automatic logic [CNTBITS-1:0] sat_inc(input logic [CNTBITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] pass_inc(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (load_en && (state_q == ST_IDLE)) begin
      tbl[load_addr]     <= load_ssid;
      exp_tbl[load_addr] <= load_expHit;
    end
  end

  // Pass index saturates so an endless run never falls back to first-pass hit expectations.
  assign exp_hit    = (rd_pass_q == 8'd0) ? exp_tbl[rd_ptr_q] : 1'b1;
  assign last_write = (n_loops_q != 8'd0) && (wr_ptr_q == last_idx_q) &&
                      (wr_pass_q == n_loops_q - 8'd1);

  always_comb begin
    state_d     = state_q;
    write_d     = 1'b0;
    ssid_d      = ssid_q;
    n_sent_d    = n_sent_q;
    n_recv_d    = n_recv_q;
    n_mis_d     = n_mis_q;
    orphan_d    = orphan_q;
    timeout_d   = timeout_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_pass_d   = wr_pass_q;
    rd_pass_d   = rd_pass_q;
    last_idx_d  = last_idx_q;
    n_loops_d   = n_loops_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ISSUE;
          n_sent_d    = '0;
          n_recv_d    = '0;
          n_mis_d     = '0;
          orphan_d    = 1'b0;
          timeout_d   = 1'b0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          wr_pass_d   = '0;
          rd_pass_d   = '0;
          // nEntries of 0 truncates to DEPTH-1, i.e. it behaves as a full table.
          last_idx_d  = ADDRBITS'(nEntries - 1'b1);
          n_loops_d   = nLoops;
          gap_d       = gap;
          gap_cnt_d   = '0;
          drain_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        if (writeReady) begin
          write_d  = 1'b1;
          ssid_d   = tbl[wr_ptr_q];
          n_sent_d = sat_inc(n_sent_q);
          if (wr_ptr_q == last_idx_q) begin
            wr_ptr_d  = '0;
            wr_pass_d = pass_inc(wr_pass_q);
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          if (last_write) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end else if (gap_q != '0) begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= GAPBITS'(1)) begin
          state_d = ST_ISSUE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (n_recv_q == n_sent_q) begin
          state_d = ST_DONE;
        end else if (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outstanding count compares against pre-write nSent, so a same-cycle write never hides an orphan.
    if ((state_q != ST_IDLE) && newOutput) begin
      if (n_recv_q == n_sent_q) begin
        orphan_d = 1'b1;
      end else begin
        n_recv_d = sat_inc(n_recv_q);
        if ((SSID_passed != tbl[rd_ptr_q]) || (hitExisted != exp_hit)) begin
          n_mis_d = sat_inc(n_mis_q);
        end
        if (rd_ptr_q == last_idx_q) begin
          rd_ptr_d  = '0;
          rd_pass_d = pass_inc(rd_pass_q);
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
    end

    // Abort freezes every visible result as it stood, including over a same-cycle start.
    if (abort) begin
      state_d   = ST_IDLE;
      write_d   = 1'b0;
      ssid_d    = ssid_q;
      n_sent_d  = n_sent_q;
      n_recv_d  = n_recv_q;
      n_mis_d   = n_mis_q;
      orphan_d  = orphan_q;
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      ssid_q      <= '0;
      n_sent_q    <= '0;
      n_recv_q    <= '0;
      n_mis_q     <= '0;
      orphan_q    <= 1'b0;
      timeout_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_pass_q   <= '0;
      rd_pass_q   <= '0;
      last_idx_q  <= '0;
      n_loops_q   <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      ssid_q      <= ssid_d;
      n_sent_q    <= n_sent_d;
      n_recv_q    <= n_recv_d;
      n_mis_q     <= n_mis_d;
      orphan_q    <= orphan_d;
      timeout_q   <= timeout_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_pass_q   <= wr_pass_d;
      rd_pass_q   <= rd_pass_d;
      last_idx_q  <= last_idx_d;
      n_loops_q   <= n_loops_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign write      = write_q;
  assign SSID_write = ssid_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign nSent      = n_sent_q;
  assign nReceived  = n_recv_q;
  assign nMismatch  = n_mis_q;
  assign orphan     = orphan_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ssid_stim_sequencer.sv
// Directed bench for ssid_stim_sequencer: a behavioural HNM with fixed latency and
// fault knobs, a table of run vectors, and hand sequences for abort, orphan and reset.
module tb_ssid_stim_sequencer;

  localparam int SW = 16;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [SW-1:0] load_ssid = '0;
  logic          load_expHit = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   nEntries = '0;
  logic [7:0]    nLoops = '0;
  logic [3:0]    gap = '0;
  logic          writeReady = 1'b0;
  logic          newOutput = 1'b0;
  logic [SW-1:0] SSID_passed = '0;
  logic          hitExisted = 1'b0;
  logic          write;
  logic [SW-1:0] SSID_write;
  logic          busy, done, orphan, timeout;
  logic [15:0]   nSent, nReceived, nMismatch;
  logic [2:0]    dbg_state;

  ssid_stim_sequencer dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_ssid(load_ssid), .load_expHit(load_expHit),
    .start(start), .abort(abort), .nEntries(nEntries), .nLoops(nLoops), .gap(gap),
    .writeReady(writeReady), .write(write), .SSID_write(SSID_write),
    .newOutput(newOutput), .SSID_passed(SSID_passed), .hitExisted(hitExisted),
    .busy(busy), .done(done), .nSent(nSent), .nReceived(nReceived), .nMismatch(nMismatch),
    .orphan(orphan), .timeout(timeout), .dbg_state(dbg_state)
  );

  // ---------------- run configuration (written by the stimulus only) ----------------
  int run_id = 0;
  int inject_req = 0;
  int ready_mode = 0;     // 0: always ready, 1: toggle every cycle, 2: held low
  int cur_gap = 0;
  int bad_ssid_idx = -1;
  int bad_hit_idx = -1;
  bit drop_last = 1'b0;
  int drop_idx = -1;

  // ---------------- HNM model and monitor (written by the model only) ----------------
  int cyc = 0;
  int seen_run = 0;
  int inject_ack = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int ready_viol = 0;
  int space_viol = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  int rsp_idx = 0;
  logic [2:0]    pipe_v = '0;
  logic [SW-1:0] pipe_s [3];
  bit            seen_set [logic [SW-1:0]];

  always @(negedge clk) begin
    logic [SW-1:0] rs;
    logic          rh;
    cyc = cyc + 1;
    if (run_id != seen_run) begin
      seen_run   = run_id;
      wr_cnt     = 0;
      done_cnt   = 0;
      ready_viol = 0;
      space_viol = 0;
      rsp_idx    = 0;
      pipe_v     = '0;
      seen_set.delete();
    end
    if (write) begin
      wr_cnt = wr_cnt + 1;
      if (!writeReady) ready_viol = ready_viol + 1;
      if (wr_cnt == 1) first_wr_cyc = cyc;
      else if (cyc - last_wr_cyc < cur_gap + 1) space_viol = space_viol + 1;
      last_wr_cyc = cyc;
    end
    if (done) done_cnt = done_cnt + 1;
    pipe_s[2] = pipe_s[1];
    pipe_s[1] = pipe_s[0];
    pipe_s[0] = SSID_write;
    pipe_v    = {pipe_v[1:0], write};
    newOutput = 1'b0;
    if (pipe_v[2]) begin
      rs = pipe_s[2];
      rh = seen_set.exists(rs);
      seen_set[rs] = 1'b1;
      if (rsp_idx == bad_ssid_idx) rs = rs ^ 16'h0001;
      if (rsp_idx == bad_hit_idx) rh = ~rh;
      if (!(drop_last && rsp_idx == drop_idx)) begin
        newOutput   = 1'b1;
        SSID_passed = rs;
        hitExisted  = rh;
      end
      rsp_idx = rsp_idx + 1;
    end
    if (inject_req != inject_ack) begin
      inject_ack  = inject_req;
      newOutput   = 1'b1;
      SSID_passed = '0;
      hitExisted  = 1'b0;
    end
    case (ready_mode)
      0:       writeReady = 1'b1;
      1:       writeReady = ~writeReady;
      default: writeReady = 1'b0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_table();
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      load_en     = 1'b1;
      load_addr   = AW'(i);
      load_ssid   = SW'(32'h1000 + (i % 19) * 7);
      load_expHit = (i >= 19);
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic begin_run(input int ne, input int nl, input int g, input int rm);
    @(negedge clk);
    ready_mode = rm;
    cur_gap    = g;
    run_id     = run_id + 1;
    repeat (2) @(negedge clk);
    nEntries = (AW + 1)'(ne);
    nLoops   = 8'(nl);
    gap      = 4'(g);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    int ne; int nl; int g; int rm;
    int bad_s; int bad_h; bit drop;
    int exp_sent; int exp_recv; int exp_mis; int exp_to;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{23, 1, 0, 0, -1, -1, 1'b0, 23, 23, 0, 0};
    vecs[1] = '{23, 2, 0, 0, -1, -1, 1'b0, 46, 46, 0, 0};
    vecs[2] = '{23, 1, 3, 1, -1, -1, 1'b0, 23, 23, 0, 0};
    vecs[3] = '{23, 1, 0, 0,  5, 10, 1'b0, 23, 23, 2, 0};
    vecs[4] = '{23, 1, 0, 0, -1, -1, 1'b1, 23, 22, 0, 1};
    vecs[5] = '{ 8, 3, 2, 1, -1, -1, 1'b0, 24, 24, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset_write", int'(write), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_counters", int'(nSent) + int'(nReceived) + int'(nMismatch), 0);
    chk("reset_sticky", int'(orphan) + int'(timeout), 0);
    chk("reset_ssid", int'(SSID_write), 0);
    reset = 1'b1;
    load_table();

    for (int v = 0; v < 6; v++) begin
      bad_ssid_idx = vecs[v].bad_s;
      bad_hit_idx  = vecs[v].bad_h;
      drop_last    = vecs[v].drop;
      drop_idx     = vecs[v].exp_sent - 1;
      begin_run(vecs[v].ne, vecs[v].nl, vecs[v].g, vecs[v].rm);
      for (int c = 0; c < 2000 && done_cnt == 0; c++) @(negedge clk);
      repeat (6) @(negedge clk);
      chk($sformatf("v%0d_writes", v), wr_cnt, vecs[v].exp_sent);
      chk($sformatf("v%0d_nSent", v), int'(nSent), vecs[v].exp_sent);
      chk($sformatf("v%0d_nReceived", v), int'(nReceived), vecs[v].exp_recv);
      chk($sformatf("v%0d_nMismatch", v), int'(nMismatch), vecs[v].exp_mis);
      chk($sformatf("v%0d_timeout", v), int'(timeout), vecs[v].exp_to);
      chk($sformatf("v%0d_orphan", v), int'(orphan), 0);
      chk($sformatf("v%0d_done_pulses", v), done_cnt, 1);
      chk($sformatf("v%0d_busy_after", v), int'(busy), 0);
      chk($sformatf("v%0d_ready_viol", v), ready_viol, 0);
      chk($sformatf("v%0d_space_viol", v), space_viol, 0);
      if (vecs[v].g == 0 && vecs[v].rm == 0)
        chk($sformatf("v%0d_b2b_span", v), last_wr_cyc - first_wr_cyc, vecs[v].exp_sent - 1);
    end
    bad_ssid_idx = -1;
    bad_hit_idx  = -1;
    drop_last    = 1'b0;

    // Orphan: nothing can be sent while writeReady is low, so any response is spurious.
    begin_run(4, 1, 0, 2);
    repeat (3) @(negedge clk);
    inject_req = inject_req + 1;
    repeat (4) @(negedge clk);
    chk("orphan_set", int'(orphan), 1);
    chk("orphan_nReceived", int'(nReceived), 0);
    chk("orphan_nSent", int'(nSent), 0);
    chk("orphan_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("orphan_abort_busy", int'(busy), 0);
    chk("orphan_abort_nodone", done_cnt, 0);

    // Endless run stopped by abort after 50 cycles.
    begin_run(23, 0, 0, 0);
    repeat (49) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_write_low", int'(write), 0);
    chk("abort_busy_low", int'(busy), 0);
    repeat (10) @(negedge clk);
    chk("abort_nodone", done_cnt, 0);
    chk("abort_nSent_hold", int'(nSent), wr_cnt);
    chk("abort_nMismatch", int'(nMismatch), 0);
    chk("abort_writes_seen", int'(wr_cnt > 40), 1);

    // Asynchronous reset in the middle of an endless run.
    begin_run(23, 0, 0, 0);
    repeat (20) @(negedge clk);
    chk("midrun_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_write", int'(write), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_nSent", int'(nSent), 0);
    chk("rst_nReceived", int'(nReceived), 0);
    chk("rst_ssid", int'(SSID_write), 0);
    chk("rst_state", int'(dbg_state), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
